// File: rtl/mem_server.sv
// rtl/mem_server.sv - CHIP-8 memory responder: 4 KiB byte RAM shared by GPU and CPU initiators
// Posted writes drain before reads; a framebuffer clear pre-empts both.
module mem_server #(
  parameter logic [11:0] FB_BASE        = 12'h100,
  parameter int          FB_BYTES       = 256,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  parameter              INIT_FILE      = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        gpu_read,
  input  logic [11:0] gpu_read_idx,
  output logic [7:0]  gpu_read_byte,
  output logic        gpu_read_ack,
  input  logic        gpu_write,
  input  logic [11:0] gpu_write_idx,
  input  logic [7:0]  gpu_write_byte,
  input  logic        cpu_read,
  input  logic [11:0] cpu_read_idx,
  output logic [7:0]  cpu_read_byte,
  output logic        cpu_read_ack,
  input  logic        cpu_write,
  input  logic [11:0] cpu_write_idx,
  input  logic [7:0]  cpu_write_byte,
  input  logic        cls,
  output logic        cls_busy,
  output logic        overflow
);

  typedef enum logic {ST_SERVE, ST_CLEAR} state_t;

  state_t      state, state_nxt;
  logic [11:0] clr_cnt;
  logic        clr_last;

  logic        gpu_wb_v, cpu_wb_v;
  logic [11:0] gpu_wb_idx, cpu_wb_idx;
  logic [7:0]  gpu_wb_byte, cpu_wb_byte;

  logic        rr_cpu;
  logic        gpu_req, cpu_req;
  logic        drain_gpu, drain_cpu, issue_gpu, issue_cpu;

  logic [7:0]  mem [0:4095];
  logic        ram_we;
  logic [11:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;

  // A port in its ack cycle is not a new request, so a held read is never served twice.
  assign gpu_req  = gpu_read & ~gpu_read_ack;
  assign cpu_req  = cpu_read & ~cpu_read_ack;
  assign clr_last = (clr_cnt == 12'(FB_BYTES - 1));
  assign cls_busy = (state == ST_CLEAR);

  always_comb begin
    state_nxt = state;
    ram_we    = 1'b0;
    ram_addr  = 12'h000;
    ram_wdata = 8'h00;
    drain_gpu = 1'b0;
    drain_cpu = 1'b0;
    issue_gpu = 1'b0;
    issue_cpu = 1'b0;
    case (state)
      ST_CLEAR: begin
        ram_we   = 1'b1;
        ram_addr = FB_BASE + clr_cnt;
        if (clr_last) state_nxt = ST_SERVE;
      end
      default: begin
        if (gpu_wb_v) begin
          drain_gpu = 1'b1;
          ram_we    = 1'b1;
          ram_addr  = gpu_wb_idx;
          ram_wdata = gpu_wb_byte;
        end else if (cpu_wb_v) begin
          drain_cpu = 1'b1;
          ram_we    = 1'b1;
          ram_addr  = cpu_wb_idx;
          ram_wdata = cpu_wb_byte;
        end else if (gpu_req && (!cpu_req || !rr_cpu)) begin
          issue_gpu = 1'b1;
          ram_addr  = gpu_read_idx;
        end else if (cpu_req) begin
          issue_cpu = 1'b1;
          ram_addr  = cpu_read_idx;
        end
        // The op chosen this cycle still completes; the clear starts next cycle.
        if (cls) state_nxt = ST_CLEAR;
      end
    endcase
  end

  // RAM contents deliberately survive reset; writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (ram_we && rst_n) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= CLEAR_ON_RESET ? ST_CLEAR : ST_SERVE;
      clr_cnt      <= 12'h000;
      gpu_read_ack <= 1'b0;
      cpu_read_ack <= 1'b0;
      gpu_wb_v     <= 1'b0;
      cpu_wb_v     <= 1'b0;
      gpu_wb_idx   <= 12'h000;
      cpu_wb_idx   <= 12'h000;
      gpu_wb_byte  <= 8'h00;
      cpu_wb_byte  <= 8'h00;
      overflow     <= 1'b0;
      rr_cpu       <= 1'b0;
    end else begin
      state        <= state_nxt;
      gpu_read_ack <= issue_gpu;
      cpu_read_ack <= issue_cpu;

      if (state == ST_CLEAR) clr_cnt <= clr_last ? 12'h000 : clr_cnt + 12'h001;
      else                   clr_cnt <= 12'h000;

      // Pointer moves only on a real tie, and always to the loser.
      if (gpu_req && cpu_req && (issue_gpu || issue_cpu)) rr_cpu <= issue_gpu;

      if (drain_gpu) gpu_wb_v <= 1'b0;
      if (gpu_write) begin
        if (gpu_wb_v) overflow <= 1'b1;
        else begin
          gpu_wb_v    <= 1'b1;
          gpu_wb_idx  <= gpu_write_idx;
          gpu_wb_byte <= gpu_write_byte;
        end
      end

      if (drain_cpu) cpu_wb_v <= 1'b0;
      if (cpu_write) begin
        if (cpu_wb_v) overflow <= 1'b1;
        else begin
          cpu_wb_v    <= 1'b1;
          cpu_wb_idx  <= cpu_write_idx;
          cpu_wb_byte <= cpu_write_byte;
        end
      end
    end
  end

  assign gpu_read_byte = gpu_read_ack ? ram_rdata : 8'h00;
  assign cpu_read_byte = cpu_read_ack ? ram_rdata : 8'h00;

endmodule

// File: tb/tb_mem_server.sv
// tb/tb_mem_server.sv - directed self-checking bench for mem_server
module tb_mem_server;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        gpu_read, gpu_write, cpu_read, cpu_write, cls;
  logic [11:0] gpu_read_idx, gpu_write_idx, cpu_read_idx, cpu_write_idx;
  logic [7:0]  gpu_write_byte, cpu_write_byte;
  logic [7:0]  gpu_read_byte, cpu_read_byte;
  logic        gpu_read_ack, cpu_read_ack, cls_busy, overflow;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_server dut (
    .clk(clk), .rst_n(rst_n),
    .gpu_read(gpu_read), .gpu_read_idx(gpu_read_idx), .gpu_read_byte(gpu_read_byte),
    .gpu_read_ack(gpu_read_ack), .gpu_write(gpu_write), .gpu_write_idx(gpu_write_idx),
    .gpu_write_byte(gpu_write_byte),
    .cpu_read(cpu_read), .cpu_read_idx(cpu_read_idx), .cpu_read_byte(cpu_read_byte),
    .cpu_read_ack(cpu_read_ack), .cpu_write(cpu_write), .cpu_write_idx(cpu_write_idx),
    .cpu_write_byte(cpu_write_byte),
    .cls(cls), .cls_busy(cls_busy), .overflow(overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input bit cpu, input logic [11:0] idx, input logic [7:0] data);
    if (cpu) begin cpu_write = 1'b1; cpu_write_idx = idx; cpu_write_byte = data; end
    else     begin gpu_write = 1'b1; gpu_write_idx = idx; gpu_write_byte = data; end
    tick();
    cpu_write = 1'b0;
    gpu_write = 1'b0;
    tick();
  endtask

  task automatic rd(input bit cpu, input logic [11:0] idx, output logic [7:0] data, output int lat);
    logic ack;
    if (cpu) begin cpu_read = 1'b1; cpu_read_idx = idx; end
    else     begin gpu_read = 1'b1; gpu_read_idx = idx; end
    lat = 0;
    do begin
      tick();
      lat++;
      ack = cpu ? cpu_read_ack : gpu_read_ack;
    end while (!ack && lat < 10);
    check("rd_ack_seen", {31'd0, ack}, 32'd1);
    data = cpu ? cpu_read_byte : gpu_read_byte;
    cpu_read = 1'b0;
    gpu_read = 1'b0;
    tick();
  endtask

  task automatic wait_clear(output int cnt);
    cnt = 0;
    while (cls_busy && cnt < 1000) begin
      cnt++;
      tick();
    end
  endtask

  initial begin
    logic [7:0] d;
    int lat, cnt;

    rst_n = 1'b0; cls = 1'b0;
    gpu_read = 1'b0; gpu_write = 1'b0; cpu_read = 1'b0; cpu_write = 1'b0;
    gpu_read_idx = '0; gpu_write_idx = '0; cpu_read_idx = '0; cpu_write_idx = '0;
    gpu_write_byte = '0; cpu_write_byte = '0;
    tick(); tick();

    // 1: reset values, 256-cycle clear, 1-cycle read of a cleared byte
    check("rst_busy", {31'd0, cls_busy}, 32'd1);
    check("rst_gack", {31'd0, gpu_read_ack}, 32'd0);
    check("rst_cack", {31'd0, cpu_read_ack}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    check("rst_gbyte", {24'd0, gpu_read_byte}, 32'd0);
    rst_n = 1'b1;
    wait_clear(cnt);
    check("clr_len_reset", cnt, 256);
    rd(1'b0, 12'h1A5, d, lat);
    check("t1_lat", lat, 1);
    check("t1_byte", {24'd0, d}, 32'h00);

    // 2: write then read; ack 3 cycles after the strobe, exactly 1 cycle wide
    gpu_write = 1'b1; gpu_write_idx = 12'h123; gpu_write_byte = 8'hAB;
    tick();
    gpu_write = 1'b0; gpu_read = 1'b1; gpu_read_idx = 12'h123;
    check("t2_ack_w1", {31'd0, gpu_read_ack}, 32'd0);
    tick();
    check("t2_ack_w2", {31'd0, gpu_read_ack}, 32'd0);
    tick();
    check("t2_ack_w3", {31'd0, gpu_read_ack}, 32'd1);
    check("t2_byte", {24'd0, gpu_read_byte}, 32'hAB);
    tick();
    check("t2_ack_w4", {31'd0, gpu_read_ack}, 32'd0);
    gpu_read = 1'b0;
    tick();

    // seed bytes for later tests; both buffers filled in one cycle drain GPU then CPU
    gpu_write = 1'b1; gpu_write_idx = 12'h010; gpu_write_byte = 8'h11;
    cpu_write = 1'b1; cpu_write_idx = 12'h020; cpu_write_byte = 8'h22;
    tick();
    gpu_write = 1'b0; cpu_write = 1'b0;
    tick(); tick();
    wr(1'b1, 12'h031, 8'h77);
    wr(1'b0, 12'h040, 8'h44);
    wr(1'b0, 12'h0FF, 8'hEE);
    wr(1'b1, 12'h200, 8'hDD);

    // 3: tie after reset goes to GPU, then CPU; next tie goes to CPU
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    wait_clear(cnt);
    gpu_read = 1'b1; gpu_read_idx = 12'h010;
    cpu_read = 1'b1; cpu_read_idx = 12'h020;
    tick();
    check("t3_gack_n1", {31'd0, gpu_read_ack}, 32'd1);
    check("t3_cack_n1", {31'd0, cpu_read_ack}, 32'd0);
    check("t3_gbyte", {24'd0, gpu_read_byte}, 32'h11);
    gpu_read = 1'b0;
    tick();
    check("t3_cack_n2", {31'd0, cpu_read_ack}, 32'd1);
    check("t3_gack_n2", {31'd0, gpu_read_ack}, 32'd0);
    check("t3_cbyte", {24'd0, cpu_read_byte}, 32'h22);
    cpu_read = 1'b0;
    tick();
    gpu_read = 1'b1; cpu_read = 1'b1;
    tick();
    check("t3_tie2_cack", {31'd0, cpu_read_ack}, 32'd1);
    check("t3_tie2_gack", {31'd0, gpu_read_ack}, 32'd0);
    cpu_read = 1'b0;
    tick();
    check("t3_tie2_gack_late", {31'd0, gpu_read_ack}, 32'd1);
    gpu_read = 1'b0;
    tick();

    // 4: back-to-back CPU writes, second dropped, overflow sticky
    check("t4_ovf_before", {31'd0, overflow}, 32'd0);
    cpu_write = 1'b1; cpu_write_idx = 12'h030; cpu_write_byte = 8'h01;
    tick();
    cpu_write_idx = 12'h031; cpu_write_byte = 8'h02;
    tick();
    cpu_write = 1'b0;
    check("t4_ovf_set", {31'd0, overflow}, 32'd1);
    tick(); tick(); tick();
    check("t4_ovf_hold", {31'd0, overflow}, 32'd1);
    rd(1'b1, 12'h030, d, lat);
    check("t4_first_kept", {24'd0, d}, 32'h01);
    rd(1'b1, 12'h031, d, lat);
    check("t4_second_dropped", {24'd0, d}, 32'h77);

    // 5: fill FB, clear with a write captured mid-clear and an ignored second cls
    for (int k = 0; k < 256; k++) begin
      gpu_write = 1'b1; gpu_write_idx = 12'h100 + 12'(k); gpu_write_byte = 8'hFF;
      tick();
      gpu_write = 1'b0;
      tick();
    end
    rd(1'b1, 12'h180, d, lat);
    check("t5_filled", {24'd0, d}, 32'hFF);
    cls = 1'b1;
    tick();
    cls = 1'b0;
    check("t5_busy_rise", {31'd0, cls_busy}, 32'd1);
    cnt = 0;
    while (cls_busy && cnt < 1000) begin
      cnt++;
      gpu_write = (cnt == 3);
      gpu_write_idx = 12'h150; gpu_write_byte = 8'h3C;
      cls = (cnt == 5);
      tick();
    end
    gpu_write = 1'b0; cls = 1'b0;
    check("t5_clr_len", cnt, 256);
    rd(1'b1, 12'h150, d, lat);
    check("t5_survivor", {24'd0, d}, 32'h3C);
    rd(1'b0, 12'h100, d, lat);
    check("t5_fb_first", {24'd0, d}, 32'h00);
    rd(1'b0, 12'h14F, d, lat);
    check("t5_fb_14f", {24'd0, d}, 32'h00);
    rd(1'b1, 12'h151, d, lat);
    check("t5_fb_151", {24'd0, d}, 32'h00);
    rd(1'b0, 12'h1FF, d, lat);
    check("t5_fb_last", {24'd0, d}, 32'h00);
    rd(1'b0, 12'h0FF, d, lat);
    check("t5_below_fb", {24'd0, d}, 32'hEE);
    rd(1'b1, 12'h200, d, lat);
    check("t5_above_fb", {24'd0, d}, 32'hDD);
    check("t5_ovf_sticky", {31'd0, overflow}, 32'd1);

    // 6: reset in the read issue cycle aborts it and empties write buffers
    gpu_read = 1'b1; gpu_read_idx = 12'h150;
    cpu_write = 1'b1; cpu_write_idx = 12'h040; cpu_write_byte = 8'h99;
    rst_n = 1'b0;
    tick();
    gpu_read = 1'b0; cpu_write = 1'b0; rst_n = 1'b1;
    check("t6_no_ack", {31'd0, gpu_read_ack}, 32'd0);
    check("t6_ovf_clr", {31'd0, overflow}, 32'd0);
    check("t6_busy", {31'd0, cls_busy}, 32'd1);
    tick();
    check("t6_no_ack_late", {31'd0, gpu_read_ack}, 32'd0);
    wait_clear(cnt);
    rd(1'b0, 12'h040, d, lat);
    check("t6_lat", lat, 1);
    check("t6_buf_flushed", {24'd0, d}, 32'h44);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
